// File: rtl/fifo_wr_arbiter_if.sv
// Requester streams and FIFO write port shared by the round-robin write arbiter.
interface fifo_wr_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_wr_en;
    logic [ID_W+DATA_WIDTH-1:0]    fifo_din;
    logic                          fifo_full;
    logic                          fifo_overflow;

    modport slave (
        input  req_valid, req_data, req_last, fifo_full, fifo_overflow,
        output req_ready, fifo_wr_en, fifo_din
    );

    modport master (
        output req_valid, req_data, req_last, fifo_full, fifo_overflow,
        input  req_ready, fifo_wr_en, fifo_din
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready streams,
// granting bounded bursts and tagging every written word with its source ID.
module fifo_wr_arbiter #(
    parameter  int DATA_WIDTH = 8,
    parameter  int NUM_REQ    = 4,
    parameter  int MAX_BURST  = 4,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    fifo_wr_arbiter_if.slave bus,
    output logic [ID_W-1:0] grant_id,
    output logic            busy,
    output logic            err_overflow,
    input  logic            err_clr
);
    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t                state, state_nxt;
    logic [ID_W-1:0]       last_grant;
    logic [CNT_W-1:0]      burst_cnt;
    logic [ID_W-1:0]       pick;
    logic                  any_valid;
    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0] g_data;
    logic                  g_valid;
    logic                  g_last;
    logic                  beat;
    logic                  burst_end;
    logic                  exit_burst;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            data_arr[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Search starts just past the last grant; k == NUM_REQ wraps back onto last_grant itself.
    always_comb begin
        logic [ID_W-1:0] idx;
        logic            found;
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = last_grant + ID_W'(k);
            if (!found && bus.req_valid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    assign any_valid  = |bus.req_valid;
    assign g_data     = data_arr[grant_id];
    assign g_valid    = bus.req_valid[grant_id];
    assign g_last     = bus.req_last[grant_id];
    assign beat       = (state == BURST) && g_valid && !bus.fifo_full;
    assign burst_end  = beat && (g_last || (burst_cnt == CNT_W'(MAX_BURST - 1)));
    assign exit_burst = (state == BURST) && (!g_valid || burst_end);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_valid) state_nxt = BURST;
            BURST:   if (exit_burst) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Write side is combinational so the FIFO samples the beat on the same edge.
    always_comb begin
        bus.req_ready  = '0;
        bus.fifo_wr_en = 1'b0;
        bus.fifo_din   = '0;
        busy           = (state == BURST);
        if (state == BURST) begin
            bus.req_ready[grant_id] = !bus.fifo_full;
        end
        if (beat) begin
            bus.fifo_wr_en = 1'b1;
            bus.fifo_din   = {grant_id, g_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_id   <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
            burst_cnt  <= '0;
        end else begin
            if (state == IDLE && any_valid) begin
                grant_id  <= pick;
                burst_cnt <= '0;
            end else if (beat) begin
                burst_cnt <= burst_cnt + CNT_W'(1);
            end
            if (exit_burst) begin
                last_grant <= grant_id;
            end
        end
    end

    // A fresh overflow pulse outranks a clear arriving in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_overflow <= 1'b0;
        end else if (bus.fifo_overflow) begin
            err_overflow <= 1'b1;
        end else if (err_clr) begin
            err_overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: reset, single stream, round-robin, stall, withdraw, errors.
module tb_fifo_wr_arbiter;
    logic       clk;
    logic       rst_n;
    logic       err_clr;
    logic [1:0] grant_id;
    logic       busy;
    logic       err_overflow;
    int         checks;
    int         errors;

    fifo_wr_arbiter_if #(.DATA_WIDTH(8), .NUM_REQ(4)) bus ();

    fifo_wr_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .MAX_BURST(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .grant_id     (grant_id),
        .busy         (busy),
        .err_overflow (err_overflow),
        .err_clr      (err_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
        bus.req_valid[i]      = v;
        bus.req_data[i*8 +: 8] = d;
        bus.req_last[i]       = l;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.req_ready, bus.fifo_wr_en, bus.fifo_din, busy, grant_id, err_overflow} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b wr_en=%b din=%h busy=%b gid=%0d err=%b, want all 0",
                     bus.req_ready, bus.fifo_wr_en, bus.fifo_din, busy, grant_id, err_overflow);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [7:0] vals [3];
        vals[0] = 8'hA1; vals[1] = 8'hA2; vals[2] = 8'hA3;
        @(negedge clk);
        set_req(2, 1'b1, vals[0], 1'b0);
        #1;
        checks++;
        if ({busy, bus.fifo_wr_en, bus.req_ready} !== 6'd0) begin
            errors++;
            $display("FAIL single_idle: busy=%b wr_en=%b ready=%b, want 0", busy, bus.fifo_wr_en, bus.req_ready);
        end
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            set_req(2, 1'b1, vals[b], (b == 2));
            #1;
            checks++;
            if ({busy, grant_id, bus.fifo_wr_en, bus.req_ready, bus.fifo_din} !== {1'b1, 2'd2, 1'b1, 4'b0100, 2'd2, vals[b]}) begin
                errors++;
                $display("FAIL single_beat%0d: busy=%b gid=%0d wr_en=%b ready=%b din=%h, want 1 2 1 0100 %h",
                         b, busy, grant_id, bus.fifo_wr_en, bus.req_ready, bus.fifo_din, {2'd2, vals[b]});
            end
        end
        @(negedge clk);
        set_req(2, 1'b0, 8'h00, 1'b0);
        #1;
        checks++;
        if ({busy, bus.fifo_wr_en} !== 2'b00) begin
            errors++;
            $display("FAIL single_exit: busy=%b wr_en=%b, want 0 0", busy, bus.fifo_wr_en);
        end
    endtask

    task automatic test_round_robin();
        int cnt [4];
        int beats;
        int id;
        do_reset();
        beats = 0;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) set_req(i, 1'b1, 8'(i*16 + cnt[i]), 1'b0);
            #1;
            checks++;
            if (bus.fifo_wr_en !== ((c % 5) != 0)) begin
                errors++;
                $display("FAIL rr_cycle%0d: wr_en=%b, want %b", c, bus.fifo_wr_en, ((c % 5) != 0));
            end
            if (bus.fifo_wr_en === 1'b1) begin
                id = int'(bus.fifo_din[9:8]);
                checks++;
                if (id != (beats / 4) % 4 || bus.fifo_din[7:0] !== 8'(id*16 + cnt[id])) begin
                    errors++;
                    $display("FAIL rr_beat%0d: din=%h, want id %0d data %h",
                             beats, bus.fifo_din, (beats / 4) % 4, 8'(((beats / 4) % 4)*16 + cnt[(beats / 4) % 4]));
                end
                cnt[id]++;
                beats++;
            end
        end
        checks++;
        if (beats != 20) begin
            errors++;
            $display("FAIL rr_total: beats=%0d, want 20", beats);
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 8'h00, 1'b0);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_end_idle: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_full_stall();
        logic [7:0] d;
        @(negedge clk);
        set_req(1, 1'b1, 8'hB0, 1'b0);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_idle: busy=%b, want 0", busy);
        end
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            d = 8'hB0 + 8'(b);
            set_req(1, 1'b1, d, 1'b0);
            #1;
            checks++;
            if ({busy, bus.fifo_wr_en, bus.fifo_din} !== {1'b1, 1'b1, 2'd1, d}) begin
                errors++;
                $display("FAIL stall_pre%0d: busy=%b wr_en=%b din=%h, want 1 1 %h", b, busy, bus.fifo_wr_en, bus.fifo_din, {2'd1, d});
            end
        end
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            bus.fifo_full = 1'b1;
            set_req(1, 1'b1, 8'hB2, 1'b0);
            #1;
            checks++;
            if ({bus.req_ready, bus.fifo_wr_en, busy} !== 6'b000001 || dut.burst_cnt !== 3'd2) begin
                errors++;
                $display("FAIL stall_hold%0d: ready=%b wr_en=%b busy=%b cnt=%0d, want 0000 0 1 2",
                         s, bus.req_ready, bus.fifo_wr_en, busy, dut.burst_cnt);
            end
        end
        for (int b = 2; b < 4; b++) begin
            @(negedge clk);
            bus.fifo_full = 1'b0;
            d = 8'hB0 + 8'(b);
            set_req(1, 1'b1, d, 1'b0);
            #1;
            checks++;
            if ({busy, bus.fifo_wr_en, bus.fifo_din} !== {1'b1, 1'b1, 2'd1, d}) begin
                errors++;
                $display("FAIL stall_post%0d: busy=%b wr_en=%b din=%h, want 1 1 %h", b, busy, bus.fifo_wr_en, bus.fifo_din, {2'd1, d});
            end
        end
        @(negedge clk);
        set_req(1, 1'b1, 8'hB4, 1'b0);
        #1;
        checks++;
        if ({busy, bus.fifo_wr_en} !== 2'b00) begin
            errors++;
            $display("FAIL stall_burst_cap: busy=%b wr_en=%b, want 0 0", busy, bus.fifo_wr_en);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({busy, bus.fifo_wr_en, bus.fifo_din} !== {1'b1, 1'b1, 2'd1, 8'hB4}) begin
            errors++;
            $display("FAIL stall_continue: busy=%b wr_en=%b din=%h, want 1 1 1b4", busy, bus.fifo_wr_en, bus.fifo_din);
        end
        @(negedge clk);
        set_req(1, 1'b0, 8'h00, 1'b0);
        #1;
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_end_idle: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_withdraw();
        @(negedge clk);
        set_req(2, 1'b1, 8'hC0, 1'b0);
        set_req(0, 1'b1, 8'hD0, 1'b0);
        #1;
        @(negedge clk);
        #1;
        checks++;
        if ({busy, grant_id, bus.fifo_wr_en, bus.fifo_din} !== {1'b1, 2'd2, 1'b1, 2'd2, 8'hC0}) begin
            errors++;
            $display("FAIL wd_grant: busy=%b gid=%0d wr_en=%b din=%h, want 1 2 1 2c0", busy, grant_id, bus.fifo_wr_en, bus.fifo_din);
        end
        @(negedge clk);
        set_req(2, 1'b0, 8'h00, 1'b0);
        #1;
        checks++;
        if ({busy, bus.fifo_wr_en} !== 2'b10) begin
            errors++;
            $display("FAIL wd_drop: busy=%b wr_en=%b, want 1 0", busy, bus.fifo_wr_en);
        end
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wd_idle: busy=%b, want 0", busy);
        end
        @(negedge clk);
        set_req(0, 1'b1, 8'hD0, 1'b1);
        #1;
        checks++;
        if ({busy, grant_id, bus.fifo_wr_en, bus.fifo_din} !== {1'b1, 2'd0, 1'b1, 2'd0, 8'hD0}) begin
            errors++;
            $display("FAIL wd_next: busy=%b gid=%0d wr_en=%b din=%h, want 1 0 1 0d0", busy, grant_id, bus.fifo_wr_en, bus.fifo_din);
        end
        @(negedge clk);
        set_req(0, 1'b0, 8'h00, 1'b0);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wd_last_idle: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_overflow();
        logic exp_err [8];
        exp_err[0] = 1'b0; exp_err[1] = 1'b1; exp_err[2] = 1'b1; exp_err[3] = 1'b1;
        exp_err[4] = 1'b1; exp_err[5] = 1'b0; exp_err[6] = 1'b0; exp_err[7] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            bus.fifo_overflow = (c == 0) || (c == 6);
            err_clr           = (c == 4) || (c == 6);
            #1;
            checks++;
            if (err_overflow !== exp_err[c]) begin
                errors++;
                $display("FAIL ovf_cycle%0d: err_overflow=%b, want %b", c, err_overflow, exp_err[c]);
            end
        end
        bus.fifo_overflow = 1'b0;
        err_clr           = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        @(negedge clk);
        set_req(3, 1'b1, 8'hE1, 1'b0);
        set_req(0, 1'b1, 8'hF0, 1'b0);
        #1;
        @(negedge clk);
        #1;
        checks++;
        if ({busy, grant_id, bus.fifo_wr_en, bus.fifo_din} !== {1'b1, 2'd3, 1'b1, 2'd3, 8'hE1}) begin
            errors++;
            $display("FAIL mid_beat1: busy=%b gid=%0d wr_en=%b din=%h, want 1 3 1 3e1", busy, grant_id, bus.fifo_wr_en, bus.fifo_din);
        end
        @(negedge clk);
        set_req(3, 1'b1, 8'hE2, 1'b0);
        #1;
        checks++;
        if ({bus.fifo_wr_en, bus.fifo_din} !== {1'b1, 2'd3, 8'hE2}) begin
            errors++;
            $display("FAIL mid_beat2: wr_en=%b din=%h, want 1 3e2", bus.fifo_wr_en, bus.fifo_din);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.req_ready, bus.fifo_wr_en, bus.fifo_din, busy, grant_id, err_overflow} !== 19'd0) begin
            errors++;
            $display("FAIL mid_async_reset: ready=%b wr_en=%b din=%h busy=%b gid=%0d err=%b, want all 0",
                     bus.req_ready, bus.fifo_wr_en, bus.fifo_din, busy, grant_id, err_overflow);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({busy, bus.fifo_wr_en} !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset_held: busy=%b wr_en=%b, want 0 0", busy, bus.fifo_wr_en);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        @(negedge clk);
        #1;
        checks++;
        if ({busy, grant_id, bus.fifo_wr_en, bus.fifo_din} !== {1'b1, 2'd0, 1'b1, 2'd0, 8'hF0}) begin
            errors++;
            $display("FAIL mid_after_reset: busy=%b gid=%0d wr_en=%b din=%h, want 1 0 1 0f0", busy, grant_id, bus.fifo_wr_en, bus.fifo_din);
        end
        @(negedge clk);
        set_req(0, 1'b0, 8'h00, 1'b0);
        set_req(3, 1'b0, 8'h00, 1'b0);
        #1;
    endtask

    initial begin
        checks            = 0;
        errors            = 0;
        err_clr           = 1'b0;
        bus.req_valid     = '0;
        bus.req_data      = '0;
        bus.req_last      = '0;
        bus.fifo_full     = 1'b0;
        bus.fifo_overflow = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_full_stall();
        test_withdraw();
        test_overflow();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the write side of the team's FIFO among `NUM_REQ` requesters. Each requester presents a valid/ready data stream. The arbiter grants one requester at a time for a bounded burst and drives the FIFO `wr_en`/`din` directly. Each word is tagged with its source ID so the read side can demultiplex. It sits in the write clock domain, in front of the FIFO write port, and throttles on the FIFO `full` flag.

## Interface
- `DATA_WIDTH`, 8: payload width per requester.
- `NUM_REQ`, 4: number of requesters; power of 2, range 2..8.
- `ID_W`, $clog2(NUM_REQ): source-tag width (derived; not overridden).
- `MAX_BURST`, 4: maximum beats per grant; range 1..16.

Ports:
- `clk`  in  1  single clock (FIFO write clock).
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  requester i has a beat on its data slice.
- `req_data`  in  NUM_REQ*DATA_WIDTH  packed payloads; requester i at [i*DATA_WIDTH +: DATA_WIDTH].
- `req_last`  in  NUM_REQ  the current beat of requester i ends its packet.
- `req_ready`  out  NUM_REQ  the beat of requester i is accepted this cycle (one-hot or zero).
- `fifo_wr_en`  out  1  write strobe to the FIFO.
- `fifo_din`  out  ID_W+DATA_WIDTH  {grant_id, payload}.
- `fifo_full`  in  1  FIFO full flag.
- `fifo_overflow`  in  1  FIFO overflow pulse.
- `grant_id`  out  ID_W  currently granted requester (valid while `busy`).
- `busy`  out  1  FSM is in BURST.
- `err_overflow`  out  1  sticky overflow error.
- `err_clr`  in  1  clears `err_overflow`.

## Operation
- FSM has two states: IDLE and BURST.
- **IDLE**
  - If any `req_valid` is set, pick the first requester with valid set, searching from `last_grant+1` upward with wrap-around modulo NUM_REQ.
  - Register the pick into `grant_id`, clear `burst_cnt`, and go to BURST.
  - `req_ready` = 0 and `fifo_wr_en` = 0 in IDLE.
- **BURST**, with g = `grant_id`
  - `req_ready[g]` = ~`fifo_full`; all other ready bits are 0.
  - A beat occurs when `req_valid[g]` & `req_ready[g]`.
  - On a beat: `fifo_wr_en`=1, `fifo_din` = {g, req_data slice g}, and `burst_cnt` increments.
- **Exit BURST to IDLE** (next cycle) on any of:
  - a beat with `req_last[g]`=1;
  - a beat with `burst_cnt` == MAX_BURST-1;
  - `req_valid[g]`=0 in a BURST cycle (requester withdrew; no beat).
  - On exit, `last_grant` <= g, so g has lowest priority at the next arbitration.
- **Full handling**
  - While `fifo_full`=1, the arbiter stalls in BURST. No beat occurs, `burst_cnt` holds, and there is no timeout.
  - A requester that holds valid keeps the grant.
- **Packet continuation**: a packet longer than MAX_BURST is split across grants. The remaining beats are sent at that requester's next grant.
- **`err_overflow`**
  - Set on a cycle with `fifo_overflow`=1; cleared by `err_clr`=1.
  - When both are high in the same cycle, set wins.
- **Widths**: `burst_cnt` is $clog2(MAX_BURST)+1 bits and never wraps (exit occurs at MAX_BURST-1).
- **Reset** (async assert, sync release):
  - state=IDLE, `grant_id`=0, `last_grant`=NUM_REQ-1 (requester 0 wins first), `burst_cnt`=0, `err_overflow`=0.
  - All outputs are 0 during reset, including `req_ready`, `fifo_wr_en`, `fifo_din` and `busy`.
- **Reset mid-burst**: the in-flight beat is discarded. The requester retries after reset; no partial state is kept.

## Timing
- State, `grant_id`, `last_grant`, `burst_cnt` and `err_overflow` are registered.
- `req_ready`, `fifo_wr_en` and `fifo_din` are combinational from registered state, `req_valid`, `req_data` and `fifo_full`.
  - The FIFO samples them on the same edge, so the data path has zero added latency.
- Arbitration latency:
  - `req_valid` rising in cycle t while IDLE gives `busy`=1 and the first possible beat in cycle t+1.
- Throughput:
  - One IDLE bubble per grant.
  - Continuous full-length bursts give MAX_BURST beats per MAX_BURST+1 cycles.
- Exit on the beat at cycle t gives IDLE at t+1 and the next grant at t+2.
- `fifo_full` is one cycle late relative to FIFO occupancy. The FIFO itself blocks the extra write; any resulting `fifo_overflow` pulse is captured in `err_overflow`.

## Test plan
- **Reset and single requester**
  - Stimulus: release `rst_n`; requester 2 sends 3 beats 0xA1, 0xA2, 0xA3 with last on 0xA3.
  - Required: `busy` rises one cycle after valid; `fifo_din` = {2,0xA1}, {2,0xA2}, {2,0xA3} on 3 consecutive cycles; IDLE on the next cycle.
- **Round-robin fairness**
  - Stimulus: all 4 requesters valid continuously with long packets, MAX_BURST=4.
  - Required: grant order 0,1,2,3,0; each grant gives exactly 4 beats; 20 beats in 25 cycles.
- **Full stall**
  - Stimulus: hold `fifo_full`=1 for 5 cycles mid-burst.
  - Required: `req_ready`=0 and `fifo_wr_en`=0 during the stall; `burst_cnt` holds; the burst resumes with the next data and no lost or duplicated beat.
- **Withdraw**
  - Stimulus: the granted requester drops valid after 1 beat.
  - Required: IDLE the next cycle; the next valid requester after it is granted.
- **Overflow sticky and clear**
  - Stimulus: pulse `fifo_overflow` for one cycle, then `err_clr`; then assert `fifo_overflow` and `err_clr` together.
  - Required: the bit sets and stays set until `err_clr`; it ends set after the simultaneous case.
- **Reset mid-burst**
  - Stimulus: assert `rst_n`=0 during beat 2.
  - Required: all outputs 0 immediately (asynchronously); after release, requester 0 has first priority.
